// File: rtl/maj_eval_pkg.sv
// rtl/maj_eval_pkg.sv - shared types and helpers for the majority-chain evaluator
package maj_eval_pkg;

    // Operand select fields are carried zero-extended to this width inside the block
    localparam int OP_SEL_MAX_W = 8;

    // Select code that always yields constant 0 (before inversion)
    localparam logic [OP_SEL_MAX_W-1:0] OP_CONST0 = '0;

    typedef struct packed {
        logic                    inv;
        logic [OP_SEL_MAX_W-1:0] sel;
    } op_field_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/maj_operand_mux.sv
// rtl/maj_operand_mux.sv - operand select decode with optional inversion
module maj_operand_mux
    import maj_eval_pkg::*;
#(
    parameter int NUM_IN    = 7,
    parameter int NUM_NODES = 8
) (
    input  op_field_t            fld,
    input  logic [NUM_IN-1:0]    vec,
    input  logic [NUM_NODES-1:0] res,
    output logic                 op
);

    logic raw;

    // Decode sel: 0 is constant 0, then primary inputs, then node results; anything else reads 0
    always_comb begin
        raw = 1'b0;
        if (fld.sel != OP_CONST0) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (fld.sel == OP_SEL_MAX_W'(i + 1)) raw = vec[i];
            end
            for (int k = 0; k < NUM_NODES; k++) begin
                if (fld.sel == OP_SEL_MAX_W'(NUM_IN + 1 + k)) raw = res[k];
            end
        end
        op = raw ^ fld.inv;
    end

endmodule

// File: rtl/maj_chain_eval.sv
// rtl/maj_chain_eval.sv - programmable majority-node chain evaluator (optional MAJ_CHAIN_EVAL_CNT_EN)
module maj_chain_eval
    import maj_eval_pkg::*;
#(
    parameter int  NUM_IN    = 7,
    parameter int  NUM_NODES = 8,
    localparam int SEL_W     = $clog2(1 + NUM_IN + NUM_NODES),
    localparam int FLD_W     = SEL_W + 1,
    localparam int ADDR_W    = $clog2(NUM_NODES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic [3*FLD_W-1:0]   cfg_data,
    input  logic                 cfg_out_we,
    input  logic [FLD_W-1:0]     cfg_out_sel,
    output logic                 cfg_err,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_IN-1:0]    in_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_bit,
    output logic                 busy
`ifdef MAJ_CHAIN_EVAL_CNT_EN
    ,
    output logic [15:0]          eval_cnt
`endif
);

    state_t                 state, state_nxt;
    logic [NUM_IN-1:0]      vec_q;
    logic [NUM_NODES-1:0]   node_res;
    logic [ADDR_W-1:0]      node_idx;
    logic [3*FLD_W-1:0]     node_cfg [NUM_NODES];
    logic [FLD_W-1:0]       out_cfg;
    op_field_t              node_fld [3];
    op_field_t              out_fld;
    logic [2:0]             node_op;
    logic                   out_op;
    logic                   addr_bad;
    logic                   idle;

    assign idle     = (state == ST_IDLE);
    assign addr_bad = (32'(cfg_addr) >= 32'(NUM_NODES));

    // Unpack the current node's three operand fields and the output select
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            node_fld[i]                = '0;
            node_fld[i].inv            = node_cfg[node_idx][i*FLD_W + SEL_W];
            node_fld[i].sel[SEL_W-1:0] = node_cfg[node_idx][i*FLD_W +: SEL_W];
        end
        out_fld                = '0;
        out_fld.inv            = out_cfg[SEL_W];
        out_fld.sel[SEL_W-1:0] = out_cfg[SEL_W-1:0];
    end

    for (genvar g = 0; g < 3; g++) begin : g_node_mux
        maj_operand_mux #(.NUM_IN(NUM_IN), .NUM_NODES(NUM_NODES)) u_mux (
            .fld (node_fld[g]),
            .vec (vec_q),
            .res (node_res),
            .op  (node_op[g])
        );
    end

    maj_operand_mux #(.NUM_IN(NUM_IN), .NUM_NODES(NUM_NODES)) u_out_mux (
        .fld (out_fld),
        .vec (vec_q),
        .res (node_res),
        .op  (out_op)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs; out_bit is forced low outside DONE
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                in_ready = !rst;
                if (in_valid) state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                if (node_idx == ADDR_W'(NUM_NODES - 1)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                out_bit   = out_op;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Latch the vector on accept, then evaluate one node per cycle in index order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q    <= '0;
            node_res <= '0;
            node_idx <= '0;
        end else if (idle && in_valid) begin
            vec_q    <= in_vec;
            node_res <= '0;
            node_idx <= '0;
        end else if (state == ST_EVAL) begin
            node_res[node_idx] <= maj3(node_op[0], node_op[1], node_op[2]);
            node_idx           <= node_idx + 1'b1;
        end
    end

    // Config writes land only in IDLE; rejected writes raise a one-cycle error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_NODES; k++) node_cfg[k] <= '0;
            out_cfg <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= (cfg_we && (!idle || addr_bad)) || (cfg_out_we && !idle);
            if (idle && cfg_we && !addr_bad) node_cfg[cfg_addr] <= cfg_data;
            if (idle && cfg_out_we)          out_cfg            <= cfg_out_sel;
        end
    end

`ifdef MAJ_CHAIN_EVAL_CNT_EN
    // Saturating count of completed output handshakes
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                            eval_cnt <= '0;
        else if (out_valid && out_ready && eval_cnt != 16'hFFFF) eval_cnt <= eval_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_maj_chain_eval.sv
// tb/tb_maj_chain_eval.sv - randomized self-checking bench for maj_chain_eval
module tb_maj_chain_eval;

    localparam int NI = 7;
    localparam int NN = 8;
    localparam int SW = 4;
    localparam int FW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_we = 1'b0;
    logic [2:0]      cfg_addr = '0;
    logic [3*FW-1:0] cfg_data = '0;
    logic            cfg_out_we = 1'b0;
    logic [FW-1:0]   cfg_out_sel = '0;
    logic            in_valid = 1'b0;
    logic [NI-1:0]   in_vec = '0;
    logic            out_ready = 1'b0;
    logic            cfg_err, in_ready, out_valid, out_bit, busy;
`ifdef MAJ_CHAIN_EVAL_CNT_EN
    logic [15:0]     eval_cnt;
`endif

    maj_chain_eval #(.NUM_IN(NI), .NUM_NODES(NN)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_out_we  (cfg_out_we),
        .cfg_out_sel (cfg_out_sel),
        .cfg_err     (cfg_err),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec      (in_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bit     (out_bit),
        .busy        (busy)
`ifdef MAJ_CHAIN_EVAL_CNT_EN
        ,
        .eval_cnt    (eval_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: configuration tables, transaction timeline, error pulse
    int            m_sel [NN][3];
    bit            m_inv [NN][3];
    int            m_osel = 0;
    bit            m_oinv = 0;
    bit            m_busy = 0;
    int            m_done_at = 0;
    logic [NI-1:0] m_vec = '0;
    bit            m_err = 0;
    int            cyc = 0;
`ifdef MAJ_CHAIN_EVAL_CNT_EN
    int            m_hs = 0;
`endif

    function automatic bit opv(input int s, input bit inv, input logic [NI-1:0] v, input bit r [NN]);
        bit x;
        x = 1'b0;
        if (s >= 1 && s <= NI)           x = v[s-1];
        else if (s > NI && s <= NI + NN) x = r[s-NI-1];
        return x ^ inv;
    endfunction

    // Evaluate the whole chain from scratch: unevaluated nodes still hold 0
    function automatic bit model_out(input logic [NI-1:0] v);
        bit r [NN];
        int votes;
        for (int k = 0; k < NN; k++) r[k] = 1'b0;
        for (int k = 0; k < NN; k++) begin
            votes = 0;
            for (int j = 0; j < 3; j++) votes += int'(opv(m_sel[k][j], m_inv[k][j], v, r));
            r[k] = (votes >= 2);
        end
        return opv(m_osel, m_oinv, v, r);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_err  <= 1'b0;
            m_osel <= 0;
            m_oinv <= 1'b0;
            for (int k = 0; k < NN; k++)
                for (int j = 0; j < 3; j++) begin
                    m_sel[k][j] <= 0;
                    m_inv[k][j] <= 1'b0;
                end
`ifdef MAJ_CHAIN_EVAL_CNT_EN
            m_hs <= 0;
`endif
        end else begin
            m_err <= (cfg_we && (m_busy || cfg_addr >= NN)) || (cfg_out_we && m_busy);
            if (!m_busy) begin
                if (cfg_we && cfg_addr < NN)
                    for (int j = 0; j < 3; j++) begin
                        m_sel[cfg_addr][j] <= int'(cfg_data[j*FW +: SW]);
                        m_inv[cfg_addr][j] <= cfg_data[j*FW + SW];
                    end
                if (cfg_out_we) begin
                    m_osel <= int'(cfg_out_sel[SW-1:0]);
                    m_oinv <= cfg_out_sel[SW];
                end
                if (in_valid) begin
                    m_busy    <= 1'b1;
                    m_done_at <= cyc + NN + 1;
                    m_vec     <= in_vec;
                end
            end else if (cyc >= m_done_at && out_ready) begin
                m_busy <= 1'b0;
`ifdef MAJ_CHAIN_EVAL_CNT_EN
                m_hs <= m_hs + 1;
`endif
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        bit ev;
        ev = m_busy && (cyc >= m_done_at);
        chk("in_ready", in_ready, !rst && !m_busy);
        chk("busy", busy, m_busy);
        chk("out_valid", out_valid, ev);
        chk("cfg_err", cfg_err, m_err);
        if (ev)  chk("out_bit", out_bit, model_out(m_vec));
        if (rst) chk("rst_out_bit", out_bit, 0);
`ifdef MAJ_CHAIN_EVAL_CNT_EN
        chk("eval_cnt", eval_cnt, m_hs);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr_node(input int a, input int sa, input int ia, input int sb, input int ib,
                           input int sc, input int ic);
        cfg_we   = 1'b1;
        cfg_addr = a[2:0];
        cfg_data = {ic[0], sc[3:0], ib[0], sb[3:0], ia[0], sa[3:0]};
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wr_out(input int s, input int inv);
        cfg_out_we  = 1'b1;
        cfg_out_sel = {inv[0], s[3:0]};
        tick();
        cfg_out_we = 1'b0;
    endtask

    // Send one vector; exp_lit < 0 means no literal expectation
    task automatic send(input logic [NI-1:0] v, input int hold, input int exp_lit,
                        input bit mid_cfg, input int rst_at);
        int lat;
        bit acc;
        in_valid = 1'b1;
        in_vec   = v;
        acc      = in_ready;
        tick();
        in_valid   = 1'b0;
        in_vec     = NI'($urandom);
        cfg_we     = 1'b0;
        cfg_out_we = 1'b0;
        chk("accept", acc, 1);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
            in_vec = NI'($urandom);
            if (lat == 4 && mid_cfg) begin
                cfg_we     = 1'b0;
                cfg_out_we = 1'b0;
                chk("mid_cfg_err", cfg_err, 1);
            end
            if (lat == 3 && mid_cfg) begin
                cfg_we      = 1'b1;
                cfg_addr    = 3'd1;
                cfg_data    = {1'b0, 4'd3, 1'b0, 4'd3, 1'b0, 4'd3};
                cfg_out_we  = 1'b1;
                cfg_out_sel = {1'b0, 4'd3};
            end
            if (lat == rst_at) begin
                rst = 1'b1;
                tick();
                tick();
                chk("rst_no_valid", out_valid, 0);
                rst = 1'b0;
                tick();
                return;
            end
        end
        chk("latency", lat, NN + 1);
        if (exp_lit >= 0) chk("lit_bit", out_bit, exp_lit);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_hs_valid", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NI-1:0] v;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cfg_err", cfg_err, 0);
        rst = 1'b0;
        tick();

        // Reset-only table: everything evaluates to 0
        send(7'h7F, 0, 0, 1'b0, 0);

        // node0 = MAJ(x0,x1,x2), out = node0; one transaction held 5 cycles in DONE
        wr_node(0, 1, 0, 2, 0, 3, 0);
        wr_out(8, 0);
        chk("model_pin_a", model_out(7'b0000011), 1);
        send(7'b0000011, 5, 1, 1'b0, 0);
        send(7'b0000100, 0, 0, 1'b0, 0);

        // node0 = MAJ(~const0, x0, const0) = x0
        wr_node(0, 0, 1, 1, 0, 0, 0);
        send(7'h01, 0, 1, 1'b0, 0);
        send(7'h00, 0, 0, 1'b0, 0);

        // node2 always 1; node1 = MAJ(node1, node2, ~const0) must see both as cleared 0
        wr_node(2, 0, 1, 0, 1, 0, 1);
        wr_node(1, 9, 0, 10, 0, 0, 1);
        wr_out(9, 0);
        chk("model_pin_fwd", model_out(7'h04), 0);
        send(7'h04, 0, 0, 1'b1, 0);
        send(7'h04, 1, 0, 1'b0, 0);
        wr_out(10, 0);
        send(7'h04, 0, 1, 1'b0, 0);

        // Reset during node 3 evaluation, then a normal vector on the cleared table
        wr_out(9, 1);
        send(7'h2A, 0, -1, 1'b0, 4);
        send(7'h55, 0, 0, 1'b0, 0);

        // Randomized tables, vectors, hold times and same-cycle accept writes
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 3)) begin
                wr_node($urandom_range(0, NN - 1), $urandom_range(0, 15), $urandom_range(0, 1),
                        $urandom_range(0, 15), $urandom_range(0, 1),
                        $urandom_range(0, 15), $urandom_range(0, 1));
            end
            if ($urandom_range(0, 2) == 0) wr_out($urandom_range(0, 15), $urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                cfg_we   = 1'b1;
                cfg_addr = 3'($urandom);
                cfg_data = 15'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                cfg_out_we  = 1'b1;
                cfg_out_sel = 5'($urandom);
            end
            v = NI'($urandom);
            send(v, $urandom_range(0, 3), -1, 1'b0, 0);
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
